// File: rtl/i2c_wb_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_wb_sequencer_if
// Description : Bundles the request/response handshake of i2c_wb_sequencer
//               with the Wishbone master bus it drives toward the i2c core.
//               master modport = sequencer side, slave modport = the
//               requester plus the i2c core (or a bench standing in for them).
// Signals     : req_valid/req_ready/req_rd/req_dev/req_mem/req_wdata  request
//               rsp_valid/rsp_rdata/rsp_err                            response
//               wb_adr_o/wb_dat_o/wb_we_o/wb_stb_o/wb_cyc_o            WB out
//               wb_dat_i/wb_ack_i                                      WB in
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_wb_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rd;
  logic [6:0] req_dev;
  logic [7:0] req_mem;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_we_o;
  logic       wb_stb_o;
  logic       wb_cyc_o;
  logic       wb_ack_i;

  modport master (
    input  req_valid, req_rd, req_dev, req_mem, req_wdata, wb_dat_i, wb_ack_i,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o
  );

  modport slave (
    output req_valid, req_rd, req_dev, req_mem, req_wdata, wb_dat_i, wb_ack_i,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o
  );
endinterface
`default_nettype wire

// File: rtl/i2c_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : i2c_wb_sequencer
// Description : Autonomous Wishbone master for the 8-bit i2c_master_top
//               register file. Initialises the prescaler/enable, then turns
//               each single-byte memory-style request into the TXR/CR/SR
//               register sequence and returns one response per request.
// Ports       : wb_clk_i  clock
//               wb_rst_i  synchronous active-high reset
//               bus       i2c_wb_sequencer_if.master (request, response, WB)
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_wb_sequencer #(
  parameter logic [15:0] PRESCALE   = 16'h00c8,
  parameter logic [19:0] POLL_LIMIT = 20'd100000,
  parameter logic [7:0]  CR_STA_WR  = 8'h90
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  i2c_wb_sequencer_if.master bus
);
  localparam logic [2:0] ADR_PRER_LO = 3'd0;
  localparam logic [2:0] ADR_PRER_HI = 3'd1;
  localparam logic [2:0] ADR_CTR     = 3'd2;
  localparam logic [2:0] ADR_TXRX    = 3'd3;
  localparam logic [2:0] ADR_CRSR    = 3'd4;
  localparam logic [7:0] CTR_EN      = 8'h80;
  localparam logic [7:0] CR_WR       = 8'h10;
  localparam logic [7:0] CR_WR_STO   = 8'h50;
  localparam logic [7:0] CR_RD_NSTO  = 8'h68;
  localparam logic [7:0] CR_STO      = 8'h40;
  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_NACK    = 2'd1;
  localparam logic [1:0] ERR_AL      = 2'd2;
  localparam logic [1:0] ERR_TMO     = 2'd3;

  typedef enum logic [3:0] {
    INIT_PRL, INIT_PRH, INIT_CTR, IDLE, W_TXR, W_CR, POLL, CHECK,
    RD_RXR, STOP_CR, STOP_POLL, RESP
  } state_t;

  state_t      state_q;
  logic [1:0]  step_q;
  logic        rd_q;
  logic [6:0]  dev_q;
  logic [7:0]  mem_q, wdata_q;
  logic        rxack_q, al_q;
  logic [1:0]  err_q;
  logic [19:0] poll_cnt_q;
  logic        req_ready_q, rsp_valid_q;
  logic [7:0]  rsp_rdata_q;
  logic [1:0]  rsp_err_q;
  logic        cyc_q, we_q;
  logic [2:0]  adr_q;
  logic [7:0]  dat_q;

  // Descriptor of the register access the current state performs.
  logic       acc_en_d, acc_we_d;
  logic [2:0] acc_adr_d;
  logic [7:0] acc_dat_d, txr_byte, cr_byte;
  logic       acc_done, poll_last;
  logic [1:0] last_step;

  assign acc_done  = cyc_q & bus.wb_ack_i;
  assign poll_last = (poll_cnt_q + 20'd1) >= POLL_LIMIT;
  assign last_step = rd_q ? 2'd3 : 2'd2;

  // Per-step TXR/CR values; a read re-addresses the slave in step 2 and
  // clocks the data byte in step 3 with a master-driven NACK plus stop.
  always_comb begin
    txr_byte = 8'h00;
    cr_byte  = CR_STA_WR;
    unique case (step_q)
      2'd0: begin txr_byte = {dev_q, 1'b0}; cr_byte = CR_STA_WR; end
      2'd1: begin txr_byte = mem_q;         cr_byte = CR_WR;     end
      2'd2: begin
        txr_byte = rd_q ? {dev_q, 1'b1} : wdata_q;
        cr_byte  = rd_q ? CR_STA_WR : CR_WR_STO;
      end
      2'd3: begin txr_byte = 8'h00;         cr_byte = CR_RD_NSTO; end
    endcase
  end

  always_comb begin
    acc_en_d  = 1'b1;
    acc_we_d  = 1'b0;
    acc_adr_d = ADR_CRSR;
    acc_dat_d = 8'h00;
    unique case (state_q)
      INIT_PRL:        begin acc_we_d = 1'b1; acc_adr_d = ADR_PRER_LO; acc_dat_d = PRESCALE[7:0];  end
      INIT_PRH:        begin acc_we_d = 1'b1; acc_adr_d = ADR_PRER_HI; acc_dat_d = PRESCALE[15:8]; end
      INIT_CTR:        begin acc_we_d = 1'b1; acc_adr_d = ADR_CTR;     acc_dat_d = CTR_EN;         end
      W_TXR:           begin acc_we_d = 1'b1; acc_adr_d = ADR_TXRX;    acc_dat_d = txr_byte;       end
      W_CR:            begin acc_we_d = 1'b1; acc_adr_d = ADR_CRSR;    acc_dat_d = cr_byte;        end
      STOP_CR:         begin acc_we_d = 1'b1; acc_adr_d = ADR_CRSR;    acc_dat_d = CR_STO;         end
      RD_RXR:          acc_adr_d = ADR_TXRX;
      POLL, STOP_POLL: acc_adr_d = ADR_CRSR;
      default:         acc_en_d  = 1'b0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= INIT_PRL;
      step_q      <= 2'd0;
      rd_q        <= 1'b0;
      dev_q       <= 7'd0;
      mem_q       <= 8'd0;
      wdata_q     <= 8'd0;
      rxack_q     <= 1'b0;
      al_q        <= 1'b0;
      err_q       <= ERR_OK;
      poll_cnt_q  <= 20'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'd0;
      rsp_err_q   <= ERR_OK;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 3'd0;
      dat_q       <= 8'd0;
    end else begin
      rsp_valid_q <= 1'b0;
      // Bus cycle: launch when idle, drop everything on ack. Because the
      // next launch only happens once cyc_q is seen low, every access is
      // followed by at least one idle cycle.
      if (acc_en_d) begin
        if (!cyc_q) begin
          cyc_q <= 1'b1;
          we_q  <= acc_we_d;
          adr_q <= acc_adr_d;
          dat_q <= acc_dat_d;
        end else if (bus.wb_ack_i) begin
          cyc_q <= 1'b0;
          we_q  <= 1'b0;
          adr_q <= 3'd0;
          dat_q <= 8'd0;
        end
      end
      case (state_q)
        INIT_PRL: if (acc_done) state_q <= INIT_PRH;
        INIT_PRH: if (acc_done) state_q <= INIT_CTR;
        INIT_CTR: if (acc_done) begin state_q <= IDLE; req_ready_q <= 1'b1; end
        IDLE: if (bus.req_valid && req_ready_q) begin
          rd_q        <= bus.req_rd;
          dev_q       <= bus.req_dev;
          mem_q       <= bus.req_mem;
          wdata_q     <= bus.req_wdata;
          step_q      <= 2'd0;
          err_q       <= ERR_OK;
          req_ready_q <= 1'b0;
          state_q     <= W_TXR;
        end
        W_TXR: if (acc_done) state_q <= W_CR;
        W_CR:  if (acc_done) begin state_q <= POLL; poll_cnt_q <= 20'd0; end
        POLL: if (acc_done) begin
          rxack_q    <= bus.wb_dat_i[7];
          al_q       <= bus.wb_dat_i[5];
          poll_cnt_q <= poll_cnt_q + 20'd1;
          if (!bus.wb_dat_i[1]) state_q <= CHECK;
          else if (poll_last) begin err_q <= ERR_TMO; state_q <= STOP_CR; end
        end
        CHECK: begin
          if (al_q) begin
            // Bus already lost: a stop would be meaningless, answer at once.
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ERR_AL;
            rsp_rdata_q <= 8'd0;
            state_q     <= RESP;
          end else if (step_q != 2'd3 && rxack_q) begin
            err_q   <= ERR_NACK;
            state_q <= STOP_CR;
          end else if (step_q == last_step) begin
            if (rd_q) state_q <= RD_RXR;
            else begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= ERR_OK;
              rsp_rdata_q <= 8'd0;
              state_q     <= RESP;
            end
          end else begin
            step_q  <= step_q + 2'd1;
            // The read-data step has no TXR byte to load.
            state_q <= (rd_q && step_q == 2'd2) ? W_CR : W_TXR;
          end
        end
        RD_RXR: if (acc_done) begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= ERR_OK;
          rsp_rdata_q <= bus.wb_dat_i;
          state_q     <= RESP;
        end
        STOP_CR: if (acc_done) begin state_q <= STOP_POLL; poll_cnt_q <= 20'd0; end
        STOP_POLL: if (acc_done) begin
          poll_cnt_q <= poll_cnt_q + 20'd1;
          if (!bus.wb_dat_i[1] || poll_last) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= bus.wb_dat_i[1] ? ERR_TMO : err_q;
            rsp_rdata_q <= 8'd0;
            state_q     <= RESP;
          end
        end
        RESP: begin
          rsp_rdata_q <= 8'd0;
          rsp_err_q   <= ERR_OK;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= INIT_PRL;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.wb_cyc_o  = cyc_q;
  assign bus.wb_stb_o  = cyc_q;
  assign bus.wb_we_o   = we_q;
  assign bus.wb_adr_o  = adr_q;
  assign bus.wb_dat_o  = dat_q;
endmodule
`default_nettype wire

// File: tb/tb_i2c_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_wb_sequencer
// Description : Bench for i2c_wb_sequencer. A behavioural i2c core + slave
//               answers the Wishbone side; requests are scored against a
//               transaction-level model of the expected response and of the
//               CR/TXR byte sequences each request should produce.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_wb_sequencer;
  localparam logic [6:0] SLAVE = 7'h10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_wb_sequencer_if bus_if ();

  i2c_wb_sequencer #(
    .PRESCALE  (16'h00c8),
    .POLL_LIMIT(20'd50),
    .CR_STA_WR (8'h90)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // ---------------- behavioural i2c core + slave ---------------------------
  logic [7:0]  slave_mem [256];
  logic [7:0]  ref_mem   [256];
  logic [7:0]  txr_m, rxr_m, ptr;
  bit          rxack_m, al_m, stuck, addressed, rw_m;
  int          phase;        // 0 idle, 1 expect address, 2 expect mem addr, 3 data
  int          tip_left, cr_idx, al_at, stuck_at, sr_reads, reads_before_cr;
  logic [63:0] cr_log, txr_log;
  int          cr_n, txr_n;
  logic [10:0] init_log [$];

  task automatic core_write(input logic [2:0] a, input logic [7:0] d);
    if (a <= 3'd2) init_log.push_back({a, d});
    if (a == 3'd3) begin
      txr_m = d; txr_log = {txr_log[55:0], d}; txr_n++;
    end
    if (a == 3'd4) begin
      cr_log = {cr_log[55:0], d}; cr_n++; cr_idx++;
      reads_before_cr = sr_reads; sr_reads = 0;
      tip_left = $urandom_range(0, 3);
      al_m = (cr_idx == al_at);
      if (stuck_at != 0 && cr_idx >= stuck_at) stuck = 1'b1;
      if (!al_m) begin
        if (d[7]) begin addressed = 1'b0; phase = 1; end
        if (d[4]) begin
          if (phase == 1) begin
            if (txr_m[7:1] == SLAVE) begin
              addressed = 1'b1; rw_m = txr_m[0]; rxack_m = 1'b0;
              phase = txr_m[0] ? 0 : 2;
            end else begin
              addressed = 1'b0; rxack_m = 1'b1; phase = 0;
            end
          end else if (addressed && !rw_m && phase == 2) begin
            ptr = txr_m; phase = 3; rxack_m = 1'b0;
          end else if (addressed && !rw_m && phase == 3) begin
            slave_mem[ptr] = txr_m; ptr = ptr + 8'd1; rxack_m = 1'b0;
          end else rxack_m = 1'b1;
        end
        if (d[5]) begin
          rxr_m = (addressed && rw_m) ? slave_mem[ptr] : 8'hff;
          ptr = ptr + 8'd1;
          rxack_m = d[3];
        end
        if (d[6]) begin addressed = 1'b0; phase = 0; end
      end
    end
  endtask

  // Registered-ack core: read data is presented together with ack.
  initial begin : core_model
    logic [7:0] rv;
    bus_if.wb_ack_i <= 1'b0;
    bus_if.wb_dat_i <= 8'h00;
    forever begin
      @(posedge clk);
      if (rst) begin
        bus_if.wb_ack_i <= 1'b0;
        bus_if.wb_dat_i <= 8'h00;
        rxack_m = 1'b0; al_m = 1'b0; stuck = 1'b0; addressed = 1'b0;
        phase = 0; tip_left = 0; sr_reads = 0;
      end else if (bus_if.wb_ack_i) begin
        bus_if.wb_ack_i <= 1'b0;
      end else if (bus_if.wb_cyc_o && bus_if.wb_stb_o && $urandom_range(0, 2) != 0) begin
        rv = 8'h00;
        if (bus_if.wb_we_o) core_write(bus_if.wb_adr_o, bus_if.wb_dat_o);
        else if (bus_if.wb_adr_o == 3'd4) begin
          rv = {rxack_m, 1'b0, al_m, 3'b000, (stuck || tip_left > 0), 1'b0};
          sr_reads++;
          if (tip_left > 0) tip_left--;
        end else if (bus_if.wb_adr_o == 3'd3) rv = rxr_m;
        bus_if.wb_ack_i <= 1'b1;
        bus_if.wb_dat_i <= rv;
      end
    end
  end

  // ---------------- scoreboard ---------------------------------------------
  typedef struct {
    logic [1:0]  err;
    logic [7:0]  rdata;
    logic [63:0] crs;
    int          ncr;
    logic [63:0] txrs;
    int          ntxr;
  } exp_t;
  exp_t exp_q [$];

  // Transaction-level expectation: walk the request's steps, stopping at
  // arbitration loss, a stalled bus (from step 2 on) or an absent device.
  task automatic push_expected(input bit rd, input logic [6:0] dev, input logic [7:0] mem,
                               input logic [7:0] wdata, input int al_k, input bit stall);
    exp_t e;
    logic [7:0] cr_seq [4];
    logic [7:0] tx_seq [4];
    int nsteps;
    cr_seq = '{8'h90, 8'h10, (rd ? 8'h90 : 8'h50), 8'h68};
    tx_seq = '{{dev, 1'b0}, mem, (rd ? {dev, 1'b1} : wdata), 8'h00};
    nsteps = rd ? 4 : 3;
    e.err = 2'd0; e.rdata = 8'h00; e.crs = 64'd0; e.ncr = 0; e.txrs = 64'd0; e.ntxr = 0;
    for (int k = 1; k <= nsteps; k++) begin
      if (k < 4) begin e.txrs = {e.txrs[55:0], tx_seq[k-1]}; e.ntxr++; end
      e.crs = {e.crs[55:0], cr_seq[k-1]}; e.ncr++;
      if (k == al_k) begin e.err = 2'd2; break; end
      if (stall && k == 2) begin e.err = 2'd3; e.crs = {e.crs[55:0], 8'h40}; e.ncr++; break; end
      if (k == 1 && dev != SLAVE) begin e.err = 2'd1; e.crs = {e.crs[55:0], 8'h40}; e.ncr++; break; end
      if (k == nsteps) begin
        if (rd) e.rdata = ref_mem[mem];
        else ref_mem[mem] = wdata;
      end
    end
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    bit   prev_rsp, ack_prev;
    prev_rsp = 1'b0; ack_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rsp = 1'b0; ack_prev = 1'b0;
      end else begin
        if (ack_prev) check("idle_after_ack", bus_if.wb_cyc_o, 1'b0);
        ack_prev = bus_if.wb_ack_i;
        if (bus_if.rsp_valid) begin
          check("ready_low_during_rsp", bus_if.req_ready, 1'b0);
          check("rsp_single_cycle", prev_rsp, 1'b0);
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_rsp: got err=%0d rdata=%0h, required no response",
                     bus_if.rsp_err, bus_if.rsp_rdata);
          end else begin
            e = exp_q.pop_front();
            check("rsp_err", bus_if.rsp_err, e.err);
            check("rsp_rdata", bus_if.rsp_rdata, e.rdata);
            check("cr_count", cr_n, e.ncr);
            check("cr_bytes", cr_log, e.crs);
            check("txr_count", txr_n, e.ntxr);
            check("txr_bytes", txr_log, e.txrs);
          end
          cr_log = 64'd0; cr_n = 0; txr_log = 64'd0; txr_n = 0;
        end
        prev_rsp = bus_if.rsp_valid;
      end
    end
  end

  // ---------------- driver -------------------------------------------------
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (bus_if.req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout: got req_ready=0 for 5000 cycles, required 1");
    end
  endtask

  task automatic drive_req(input bit rd, input logic [6:0] dev, input logic [7:0] mem,
                           input logic [7:0] wdata);
    bus_if.req_rd = rd; bus_if.req_dev = dev; bus_if.req_mem = mem;
    bus_if.req_wdata = wdata; bus_if.req_valid = 1'b1;
  endtask

  task automatic wait_rsp(input bit pulse);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk); #1;
      bus_if.req_valid = 1'b0;
      if (exp_q.size() == 0) begin done = 1'b1; break; end
      // Request offered while busy: must be ignored.
      if (pulse && i == 3 && !bus_if.req_ready)
        drive_req($urandom_range(0, 1), SLAVE, 8'($urandom), 8'($urandom));
    end
    bus_if.req_valid = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL rsp_timeout: got %0d pending responses, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic send(input bit rd, input logic [6:0] dev, input logic [7:0] mem,
                      input logic [7:0] wdata, input int al_k, input bit stall, input bit pulse);
    bit ok;
    wait_ready(ok);
    if (ok) begin
      cr_idx = 0; al_at = al_k; stuck_at = stall ? 2 : 0;
      push_expected(rd, dev, mem, wdata, al_k, stall);
      drive_req(rd, dev, mem, wdata);
      @(negedge clk);
      bus_if.req_valid = 1'b0;
      wait_rsp(pulse);
    end
  endtask

  task automatic check_init();
    bit ok;
    wait_ready(ok);
    check("init_write_count", init_log.size(), 3);
    if (init_log.size() >= 3) begin
      check("init_prer_lo", init_log[0], {3'd0, 8'hc8});
      check("init_prer_hi", init_log[1], {3'd1, 8'h00});
      check("init_ctr", init_log[2], {3'd2, 8'h80});
    end
    init_log.delete();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit          ok, rd;
    logic [6:0]  dev;
    int          al_k;
    bus_if.req_valid = 1'b0; bus_if.req_rd = 1'b0; bus_if.req_dev = 7'd0;
    bus_if.req_mem = 8'd0; bus_if.req_wdata = 8'd0;
    cr_idx = 0; al_at = 0; stuck_at = 0; cr_log = 64'd0; txr_log = 64'd0;
    cr_n = 0; txr_n = 0; txr_m = 8'd0; rxr_m = 8'd0; ptr = 8'd0; rw_m = 1'b0;
    reads_before_cr = 0;
    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = 8'(i) ^ 8'h3c;
      ref_mem[i]   = 8'(i) ^ 8'h3c;
    end

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus_if.req_ready, 1'b0);
    check("rst_rsp_valid", bus_if.rsp_valid, 1'b0);
    check("rst_rsp_rdata", bus_if.rsp_rdata, 8'h00);
    check("rst_rsp_err", bus_if.rsp_err, 2'd0);
    check("rst_cyc", bus_if.wb_cyc_o, 1'b0);
    check("rst_stb", bus_if.wb_stb_o, 1'b0);
    check("rst_we", bus_if.wb_we_o, 1'b0);
    check("rst_adr", bus_if.wb_adr_o, 3'd0);
    check("rst_dat", bus_if.wb_dat_o, 8'h00);
    rst = 1'b0;
    check_init();

    // Directed: write, read-back, absent device.
    send(1'b0, SLAVE, 8'h01, 8'ha5, 0, 1'b0, 1'b0);
    check("slave_mem_01", slave_mem[1], 8'ha5);
    send(1'b1, SLAVE, 8'h01, 8'h00, 0, 1'b0, 1'b1);
    send(1'b0, 7'h11, 8'h02, 8'h5a, 0, 1'b0, 1'b0);

    // Stalled bus from step 1: both the step poll and the stop poll time out.
    send(1'b0, SLAVE, 8'h03, 8'h77, 0, 1'b1, 1'b0);
    check("timeout_sr_reads", reads_before_cr, 50);
    check("stop_sr_reads", sr_reads, 50);
    stuck = 1'b0; stuck_at = 0;

    // Arbitration loss on the final step of a read and a middle write step.
    send(1'b1, SLAVE, 8'h01, 8'h00, 4, 1'b0, 1'b0);
    send(1'b0, SLAVE, 8'h04, 8'h33, 2, 1'b0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      rd  = 1'($urandom_range(0, 1));
      dev = ($urandom_range(0, 9) < 7) ? SLAVE : 7'($urandom);
      if (dev == SLAVE && $urandom_range(0, 9) >= 7) dev = 7'h11;
      al_k = ($urandom_range(0, 9) == 0) ? $urandom_range(1, rd ? 4 : 3) : 0;
      send(rd, dev, 8'($urandom_range(0, 7)), 8'($urandom), al_k, 1'b0,
           1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a stalled poll; the busy-time request is lost.
    wait_ready(ok);
    cr_idx = 0; al_at = 0; stuck_at = 2;
    drive_req(1'b0, SLAVE, 8'h05, 8'h99);
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (sr_reads >= 10) begin ok = 1'b1; break; end
    end
    check("stall_reached", ok, 1'b1);
    drive_req(1'b1, SLAVE, 8'h06, 8'h00);
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    stuck_at = 0;
    init_log.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_cyc", bus_if.wb_cyc_o, 1'b0);
    check("midrst_stb", bus_if.wb_stb_o, 1'b0);
    check("midrst_ready", bus_if.req_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cr_log = 64'd0; cr_n = 0; txr_log = 64'd0; txr_n = 0;
    check_init();
    send(1'b1, SLAVE, 8'h01, 8'h00, 0, 1'b0, 1'b0);
    repeat (200) @(negedge clk);
    check("no_pending_rsp", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/i2c_wb_sequencer.md
Name: i2c_wb_sequencer

Overview:
Autonomous Wishbone master that sits directly upstream of i2c_master_top and drives its 8-bit register interface. It accepts single-byte memory-style requests (device address, memory address, data, read/write). It performs the full register sequence on the core: prescale/enable init, TXR/CR writes, SR polling, RxACK/AL checks and RXR readback. It returns one response per request, replacing hand-written register bit-banging by software or bench tasks.

Parameters:
PRESCALE, 16'h00c8, value written to PRER_HI:PRER_LO during init
POLL_LIMIT, 20'd100000, max SR reads per poll phase before timeout
CR_STA_WR, 8'h90, CR value for start+write (fixed encoding; not meant to be overridden)

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset
req_valid  in  1  request present
req_ready  out  1  sequencer idle, request accepted when valid&ready
req_rd  in  1  1=read, 0=write
req_dev  in  7  7-bit slave address
req_mem  in  8  slave memory address byte
req_wdata  in  8  write data
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  8  read data (0 for writes/errors)
rsp_err  out  2  0 ok, 1 NACK, 2 arbitration lost, 3 poll timeout
wb_adr_o  out  3  core register address
wb_dat_o  out  8  write data to core
wb_dat_i  in  8  read data from core
wb_we_o  out  1  write enable
wb_stb_o  out  1  strobe
wb_cyc_o  out  1  cycle
wb_ack_i  in  1  core acknowledge

Behaviour:
- One clock wb_clk_i; reset wb_rst_i is synchronous, active-high.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=0, wb_dat_o=0. State=INIT.
- Register map: 0 PRER_LO, 1 PRER_HI, 2 CTR, 3 TXR(w)/RXR(r), 4 CR(w)/SR(r).
- SR bits: 7 RxACK, 5 AL, 1 TIP.
- Wishbone access: cyc/stb/we/adr/dat set together and held until wb_ack_i=1. All are deasserted the cycle after ack. At least one idle cycle separates accesses, so a registered core ack cannot double-count. Read data is captured on the ack cycle.
- INIT after reset: PRER_LO=PRESCALE[7:0], then PRER_HI=PRESCALE[15:8], then CTR=8'h80. Go to IDLE; req_ready=1 only in IDLE.
- Accept: on valid&ready, latch all req_* fields. req_ready drops the next cycle. Requests while not ready are ignored.
- Step = write TXR, write CR, then POLL: read SR until TIP=0.
  - Write request: step0 TXR={dev,0}, CR=8'h90; step1 TXR=mem, CR=8'h10; step2 TXR=wdata, CR=8'h50 (write+stop).
  - Read request: step0 and step1 as for write; step2 TXR={dev,1}, CR=8'h90 (repeated start); step3 CR only, 8'h68 (read+NACK+stop). Then read RXR into rsp_rdata.
- CHECK after each poll, using the final SR value:
  - AL=1: err=2, no stop, go to RESP.
  - Otherwise, for write-type steps with RxACK=1: err=1, go to STOP.
  - Step3 ignores RxACK (the master drives NACK itself).
- Poll counter resets at each POLL entry. Reaching POLL_LIMIT SR reads with TIP still 1 gives err=3 and goes to STOP.
- STOP: CR=8'h40, then poll TIP=0, bounded by POLL_LIMIT. A second timeout still goes to RESP with err=3.
- RESP: rsp_valid=1 for exactly one cycle with rdata/err valid; next cycle IDLE, req_ready=1. rsp_rdata=0 unless read ok.
- State list: INIT_PRL, INIT_PRH, INIT_CTR, IDLE, W_TXR, W_CR, POLL, CHECK, RD_RXR, STOP_CR, STOP_POLL, RESP.
- Reset mid-operation: the abandoned bus cycle drops on the next edge and the sequencer restarts at INIT. The i2c core shares the same reset.
- req accepted in the same cycle as rsp_valid: impossible; ready is low during RESP.

Test Plan:
- Reset, PRESCALE=16'h00c8, monitor WB -> writes (0,c8),(1,00),(2,80) in order; then req_ready=1.
- Write dev=7'h10 mem=01 data=a5 to the i2c slave model -> CR sequence 90,10,50; rsp_valid one cycle, err=0; slave mem[01]=a5.
- Read dev=7'h10 mem=01 -> CR sequence 90,10,90,68; rsp_rdata=a5, err=0; TXR third write = 8'h21.
- Write to absent dev=7'h11 -> RxACK=1 after step0; CR=40 issued; rsp_err=1, rsp_rdata=0.
- POLL_LIMIT=50, force scl low during step1 -> rsp_err=3 after 50 SR reads; stop attempted; returns IDLE.
- Assert wb_rst_i mid-poll; pulse req_valid while busy -> no rsp; cyc/stb drop next edge; INIT rerun; busy-time request never answered.
